// File: rtl/display_pkg.sv
// Shared constants for the 7-segment view sequencer: view codes, debounce states, digit selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

   localparam logic [1:0] VIEW_PC  = 2'd0;
   localparam logic [1:0] VIEW_RS  = 2'd1;
   localparam logic [1:0] VIEW_RT  = 2'd2;
   localparam logic [1:0] VIEW_ALU = 2'd3;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } db_state_t;

   localparam logic [3:0] SEL_BLANK = 4'b1111;
   localparam logic [3:0] SEL_DIG0  = 4'b0111;
   localparam logic [3:0] SEL_DIG1  = 4'b1011;
   localparam logic [3:0] SEL_DIG2  = 4'b1101;
   localparam logic [3:0] SEL_DIG3  = 4'b1110;

   // Digit index used after a blanking event, so the next scan step lands on digit 0.
   localparam logic [1:0] DIGIT_LAST = 2'd3;

   function automatic logic [3:0] sel_decode(input logic [1:0] idx);
      logic [3:0] sel;
      case (idx)
         2'd0:    sel = SEL_DIG0;
         2'd1:    sel = SEL_DIG1;
         2'd2:    sel = SEL_DIG2;
         default: sel = SEL_DIG3;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/display_view_ctrl_if.sv
// Button input and display-side outputs of the view sequencer (auto_en only with DISPLAY_AUTO_CYCLE_EN).
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are free-running level/pulse signals.
interface display_view_if;
   import display_pkg::*;

   logic       btn_next;
`ifdef DISPLAY_AUTO_CYCLE_EN
   logic       auto_en;
`endif
   logic [1:0] view;
   logic       view_changed;
   logic       scan_tick;
   logic [1:0] digit_idx;
   logic [3:0] select;

   modport master (
`ifdef DISPLAY_AUTO_CYCLE_EN
      output auto_en,
`endif
      output btn_next,
      input  view, view_changed, scan_tick, digit_idx, select
   );

   modport slave (
`ifdef DISPLAY_AUTO_CYCLE_EN
      input  auto_en,
`endif
      input  btn_next,
      output view, view_changed, scan_tick, digit_idx, select
   );
endinterface

// File: rtl/display_view_ctrl_btn_debounce.sv
// Synchronises the raw button and emits one step pulse per debounced press.
// Latency: step fires DEBOUNCE_CYCLES+3 cycles after a clean press reaches the pin.
// Backpressure: none; holding the button never repeats, releases must also be stable.
module btn_debounce
   import display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic clk_base,
   input  logic rst_n,
   input  logic btn,
   output logic step
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta;
   logic             s;
   db_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // Two-flop synchroniser; nothing else looks at the raw pin.
   always_ff @(posedge clk_base or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         s    <= 1'b0;
      end else begin
         meta <= btn;
         s    <= meta;
      end
   end

   // Debounce state and stability counter.
   always_ff @(posedge clk_base or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state; step is raised only on the press-acceptance transition.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (s) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = HELD;
               step      = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HELD: begin
            if (!s) begin
               state_nxt = REL_WAIT;
               cnt_nxt   = '0;
            end
         end
         REL_WAIT: begin
            if (s) begin
               state_nxt = HELD;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: rtl/display_view_ctrl.sv
// View selector and digit-scan sequencer for the 4-digit display; DISPLAY_AUTO_CYCLE_EN adds auto-advance.
// Latency: view and view_changed update on the edge after a step; scan_tick every SCAN_DIV cycles.
// Backpressure: none; a step restarts the scan blanked and wins over a coincident scan tick.
module display_view_ctrl
   import display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int SCAN_DIV        = 40000,
   parameter int AUTO_CYCLES     = 50000000
) (
   input logic          clk_base,
   input logic          rst_n,
   display_view_if.slave dsp
);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   logic              btn_step;
   logic              auto_step;
   logic              step;
   logic              scan_wrap;
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        digit_nxt;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk_base(clk_base),
      .rst_n   (rst_n),
      .btn     (dsp.btn_next),
      .step    (btn_step)
   );

`ifdef DISPLAY_AUTO_CYCLE_EN
   localparam int AUTO_W = $clog2(AUTO_CYCLES);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

   logic [AUTO_W-1:0] auto_cnt;

   assign auto_step = dsp.auto_en && (auto_cnt == AUTO_LAST);

   // Idle timer: restarts on any step or while auto-advance is disabled.
   always_ff @(posedge clk_base or negedge rst_n) begin
      if (!rst_n) begin
         auto_cnt <= '0;
      end else if (!dsp.auto_en || step) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + 1'b1;
      end
   end
`else
   // Keeps the auto-advance parameter referenced in builds without the timer.
   logic unused_auto;
   assign unused_auto = (AUTO_CYCLES > 1);
   assign auto_step   = 1'b0;
`endif

   // A simultaneous button and auto step collapse into one increment.
   assign step      = btn_step | auto_step;
   assign scan_wrap = (scan_cnt == SCAN_LAST);
   assign digit_nxt = dsp.digit_idx + 2'd1;

   // View register; view_changed marks the first cycle of a new view.
   always_ff @(posedge clk_base or negedge rst_n) begin
      if (!rst_n) begin
         dsp.view         <= VIEW_PC;
         dsp.view_changed <= 1'b0;
      end else begin
         dsp.view_changed <= step;
         if (step) begin
            dsp.view <= dsp.view + 2'd1;
         end
      end
   end

   // Scan divider and digit select; a step blanks and restarts so the next tick shows digit 0.
   always_ff @(posedge clk_base or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt      <= '0;
         dsp.scan_tick <= 1'b0;
         dsp.digit_idx <= DIGIT_LAST;
         dsp.select    <= SEL_BLANK;
      end else if (step) begin
         scan_cnt      <= '0;
         dsp.scan_tick <= 1'b0;
         dsp.digit_idx <= DIGIT_LAST;
         dsp.select    <= SEL_BLANK;
      end else begin
         dsp.scan_tick <= scan_wrap;
         if (scan_wrap) begin
            scan_cnt      <= '0;
            dsp.digit_idx <= digit_nxt;
            dsp.select    <= sel_decode(digit_nxt);
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_display_view_ctrl.sv
// Self-checking bench for display_view_ctrl (DISPLAY_AUTO_CYCLE_EN section runs only when defined).
// Latency: n/a.
// Backpressure: n/a.
module tb_display_view_ctrl;
   import display_pkg::*;

   localparam int DC = 4;
   localparam int SD = 3;
   localparam int AC = 20;

   logic clk_base = 1'b0;
   logic rst_n    = 1'b1;
   bit   chk_en   = 1'b0;
   int   checks   = 0;
   int   errors   = 0;
   int   vc_count = 0;

   display_view_if dsp();

   display_view_ctrl #(
      .DEBOUNCE_CYCLES(DC),
      .SCAN_DIV       (SD),
      .AUTO_CYCLES    (AC)
   ) dut (
      .clk_base(clk_base),
      .rst_n   (rst_n),
      .dsp     (dsp)
   );

   always #5 clk_base = ~clk_base;

   // Reference model: run-length debounce, phase-since-restart scan, counted ticks give the digit.
   logic       m_q1 = 1'b0, m_q2 = 1'b0, m_prev = 1'b0;
   int         m_run = 0, m_phase = 0, m_ticks = 0, m_en_run = 0;
   bit         m_armed = 1'b1;
   logic [1:0] e_view = 2'd0, e_digit = 2'd3;
   logic [3:0] e_sel = 4'hf;
   logic       e_tick = 1'b0, e_vc = 1'b0;

   always @(posedge clk_base or negedge rst_n) begin
      logic s;
      bit   bstep, astep, stp;
      if (!rst_n) begin
         m_q1 = 0; m_q2 = 0; m_prev = 0; m_run = 0; m_phase = 0; m_ticks = 0;
         m_en_run = 0; m_armed = 1; e_view = 0; e_digit = 3; e_sel = 4'hf;
         e_tick = 0; e_vc = 0;
      end else begin
         s = m_q2;
         if (s == m_prev) m_run++; else m_run = 1;
         m_prev = s;
         bstep = m_armed && s && (m_run == DC + 1);
         if (bstep) m_armed = 0;
         else if (!m_armed && !s && (m_run == DC + 1)) m_armed = 1;
         astep = 0;
`ifdef DISPLAY_AUTO_CYCLE_EN
         if (dsp.auto_en) m_en_run++; else m_en_run = 0;
         astep = (m_en_run == AC);
`endif
         stp = bstep || astep;
         if (stp) begin
            m_en_run = 0;
            e_view   = e_view + 2'd1;
            m_phase  = 0;
            m_ticks  = 0;
            e_tick   = 0;
         end else begin
            m_phase++;
            e_tick = (m_phase % SD == 0);
            if (e_tick) m_ticks++;
         end
         e_vc    = stp;
         e_digit = 2'((3 + m_ticks) % 4);
         e_sel   = (m_ticks == 0) ? 4'hf : ~(4'b1000 >> e_digit);
         m_q2 = m_q1;
         m_q1 = dsp.btn_next;
      end
   end

   // Every cycle: all outputs against the model.
   always @(negedge clk_base) begin
      if (chk_en) begin
         checks++;
         if ({dsp.view, dsp.view_changed, dsp.scan_tick, dsp.digit_idx, dsp.select} !==
             {e_view, e_vc, e_tick, e_digit, e_sel}) begin
            errors++;
            $display("FAIL model t=%0t got view=%0d vc=%0b tick=%0b idx=%0d sel=%b exp view=%0d vc=%0b tick=%0b idx=%0d sel=%b",
                     $time, dsp.view, dsp.view_changed, dsp.scan_tick, dsp.digit_idx, dsp.select,
                     e_view, e_vc, e_tick, e_digit, e_sel);
         end
      end
   end

   // view_changed pulses seen so far (sampled before the DUT updates).
   always @(posedge clk_base) begin
      if (dsp.view_changed === 1'b1) vc_count++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_view"}, 32'(dsp.view), 32'd0);
      check({name, "_vc"},   32'(dsp.view_changed), 32'd0);
      check({name, "_tick"}, 32'(dsp.scan_tick), 32'd0);
      check({name, "_idx"},  32'(dsp.digit_idx), 32'd3);
      check({name, "_sel"},  32'(dsp.select), 32'hf);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk_base);
         n++;
      end while (!dsp.scan_tick && n < 20);
   endtask

   task automatic wait_vc(output int n);
      n = 0;
      do begin
         @(negedge clk_base);
         n++;
      end while (!dsp.view_changed && n < 60);
   endtask

   typedef struct {
      logic       btn;
      int         cycles;
      logic [1:0] view;
      int         steps;
   } vec_t;

   vec_t tbl[24];

   localparam logic [3:0] SEL_SEQ [5] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};

   initial begin
      int n, base;
      tbl[0]  = '{1'b1, 2,  2'd0, 0};
      tbl[1]  = '{1'b0, 10, 2'd0, 0};
      tbl[2]  = '{1'b1, 12, 2'd1, 1};
      tbl[3]  = '{1'b0, 10, 2'd1, 1};
      tbl[4]  = '{1'b1, 10, 2'd2, 2};
      tbl[5]  = '{1'b0, 10, 2'd2, 2};
      tbl[6]  = '{1'b1, 10, 2'd3, 3};
      tbl[7]  = '{1'b0, 10, 2'd3, 3};
      tbl[8]  = '{1'b1, 10, 2'd0, 4};
      tbl[9]  = '{1'b0, 10, 2'd0, 4};
      tbl[10] = '{1'b1, 10, 2'd1, 5};
      tbl[11] = '{1'b0, 10, 2'd1, 5};
      tbl[12] = '{1'b1, 10, 2'd2, 6};
      tbl[13] = '{1'b0, 2,  2'd2, 6};
      tbl[14] = '{1'b1, 2,  2'd2, 6};
      tbl[15] = '{1'b0, 3,  2'd2, 6};
      tbl[16] = '{1'b1, 1,  2'd2, 6};
      tbl[17] = '{1'b0, 10, 2'd2, 6};
      tbl[18] = '{1'b1, 3,  2'd2, 6};
      tbl[19] = '{1'b0, 1,  2'd2, 6};
      tbl[20] = '{1'b1, 4,  2'd2, 6};
      tbl[21] = '{1'b0, 10, 2'd2, 6};
      tbl[22] = '{1'b1, 10, 2'd3, 7};
      tbl[23] = '{1'b0, 10, 2'd3, 7};

      dsp.btn_next = 1'b0;
`ifdef DISPLAY_AUTO_CYCLE_EN
      dsp.auto_en = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      @(negedge clk_base);
      #1 check_reset_outputs("reset");
      @(negedge clk_base);
      #2 rst_n = 1'b1;

      // Scan sequence after reset: first tick 3 edges after release, then every 3.
      for (int k = 0; k < 5; k++) begin
         wait_tick(n);
         check("tick_gap", 32'(n), 32'd3);
         check("tick_sel", 32'(dsp.select), 32'(SEL_SEQ[k]));
         check("tick_idx", 32'(dsp.digit_idx), 32'(k % 4));
      end

      // Table: press/release/bounce segments with cumulative view and step count.
      base = vc_count;
      for (int i = 0; i < 24; i++) begin
         for (int c = 0; c < tbl[i].cycles; c++) begin
            @(negedge clk_base);
            dsp.btn_next = tbl[i].btn;
         end
         check($sformatf("vec%0d_view", i), 32'(dsp.view), 32'(tbl[i].view));
         check($sformatf("vec%0d_steps", i), 32'(vc_count - base), 32'(tbl[i].steps));
      end

      // Step lands on the same edge as a scan tick: tick dropped, display blanked.
      wait_tick(n);
      check("pre_collide_tick", 32'(n <= 3), 32'd1);
      @(negedge clk_base);
      @(negedge clk_base);
      dsp.btn_next = 1'b1;
      repeat (7) @(negedge clk_base);
      check("collide_vc",   32'(dsp.view_changed), 32'd1);
      check("collide_tick", 32'(dsp.scan_tick), 32'd0);
      check("collide_idx",  32'(dsp.digit_idx), 32'd3);
      check("collide_sel",  32'(dsp.select), 32'hf);
      repeat (3) @(negedge clk_base);
      check("after_collide_tick", 32'(dsp.scan_tick), 32'd1);
      check("after_collide_sel",  32'(dsp.select), 32'b0111);
      dsp.btn_next = 1'b0;
      repeat (12) @(negedge clk_base);

      // Reset in the middle of PRESS_WAIT, then with the button held (HELD).
      dsp.btn_next = 1'b1;
      repeat (4) @(negedge clk_base);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_pw");
      @(negedge clk_base);
      #2 rst_n = 1'b1;
      wait_vc(n);
      check("rst_pw_latency", 32'(n), 32'd7);
      check("rst_pw_view", 32'(dsp.view), 32'd1);
      repeat (3) @(negedge clk_base);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_held");
      @(negedge clk_base);
      #2 rst_n = 1'b1;
      wait_vc(n);
      check("rst_held_latency", 32'(n), 32'd7);
      check("rst_held_view", 32'(dsp.view), 32'd1);
      dsp.btn_next = 1'b0;
      repeat (12) @(negedge clk_base);

      // Random button activity against the model.
      for (int i = 0; i < 60; i++) begin
         int len;
         logic b;
         b   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         for (int c = 0; c < len; c++) begin
            @(negedge clk_base);
            dsp.btn_next = b;
         end
      end
      dsp.btn_next = 1'b0;
      repeat (12) @(negedge clk_base);

`ifdef DISPLAY_AUTO_CYCLE_EN
      // Auto-advance every AC cycles; a press restarts the timer; disabling stops it.
      dsp.auto_en = 1'b1;
      wait_vc(n);
      wait_vc(n);
      check("auto_gap", 32'(n), 32'(AC));
      repeat (3) @(negedge clk_base);
      dsp.btn_next = 1'b1;
      wait_vc(n);
      check("auto_press_gap", 32'(n), 32'd7);
      repeat (3) @(negedge clk_base);
      dsp.btn_next = 1'b0;
      wait_vc(n);
      check("auto_restart_gap", 32'(n + 3), 32'(AC));
      dsp.auto_en = 1'b0;
      base = vc_count;
      repeat (45) @(negedge clk_base);
      check("auto_off_steps", 32'(vc_count - base), 32'd0);
`endif

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
